// File: rtl/mc_fork.sv
// mc_fork: multicast fork stage with a one-entry output register.
// Unicast packets pass straight through on the decoded port. Forward-and-absorb
// packets are first delivered to LOCAL while being captured. They are then
// replayed on the decoded port, with the head bitmap replaced by the decoder's
// own-node-cleared bitmap.
module mc_fork #(
  parameter int FLITW  = 64,
  parameter int MAXLEN = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLITW-1:0] in_flit,
  input  logic [2:0]       dec_port,
  input  logic [19:0]      dec_addr1_rm,
  input  logic             dec_fwdab_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLITW-1:0] out_flit,
  output logic [2:0]       out_port,
  output logic             err
);

  localparam int PW = $clog2(MAXLEN + 1);
  localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [PW-1:0] MAXLEN_P = PW'(MAXLEN);
  localparam logic [2:0] PORT_LOCAL = 3'd4;

  typedef enum logic [1:0] {IDLE, PASS, CAPT, REPLAY} state_t;

  state_t state, state_nxt;

  logic [2:0]       lat_port;
  logic [19:0]      lat_addr;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             ovf;
  logic [FLITW-1:0] cap_buf [MAXLEN];

  logic             out_free, accept, in_head, in_tail;
  logic [1:0]       in_type;
  logic [FLITW-1:0] rep_raw, rep_flit;
  logic             rep_last;

  logic             load_out, cap_we, rd_inc, set_err, set_ovf, latch_hdr;
  logic [FLITW-1:0] nxt_flit;
  logic [2:0]       nxt_port;

  // The forward-and-absorb flag needs no register of its own: choosing CAPT
  // over PASS already records it.
  assign out_free = !out_valid || out_ready;
  assign in_ready = rst_ && (state != REPLAY) && out_free;
  assign accept   = in_valid && in_ready;
  assign in_type  = in_flit[FLITW-1:FLITW-2];
  assign in_head  = in_type[0];
  assign in_tail  = in_type[1];

  assign rep_raw  = cap_buf[rd_ptr[IW-1:0]];
  assign rep_last = ((rd_ptr + PW'(1)) == wr_ptr);

  // Build the replay copy: rewrite the head bitmap, and close a truncated packet with a tail type
  always_comb begin
    rep_flit = rep_raw;
    if (rep_raw[FLITW-2]) begin
      rep_flit[19:0] = lat_addr;
    end
    if (rep_last && ovf) begin
      rep_flit[FLITW-1:FLITW-2] = 2'b10;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    nxt_flit  = in_flit;
    nxt_port  = lat_port;
    cap_we    = 1'b0;
    rd_inc    = 1'b0;
    set_err   = 1'b0;
    set_ovf   = 1'b0;
    latch_hdr = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_head) begin
            latch_hdr = 1'b1;
            load_out  = 1'b1;
            if (dec_fwdab_en) begin
              nxt_port  = PORT_LOCAL;
              cap_we    = 1'b1;
              state_nxt = in_tail ? REPLAY : CAPT;
            end else begin
              nxt_port  = dec_port;
              state_nxt = in_tail ? IDLE : PASS;
            end
          end else begin
            set_err = 1'b1;
          end
        end
      end
      PASS: begin
        if (accept) begin
          load_out = 1'b1;
          if (in_tail) begin
            state_nxt = IDLE;
          end
        end
      end
      CAPT: begin
        if (accept) begin
          load_out = 1'b1;
          nxt_port = PORT_LOCAL;
          if (wr_ptr < MAXLEN_P) begin
            cap_we = 1'b1;
          end else begin
            set_err = 1'b1;
            set_ovf = 1'b1;
          end
          if (in_tail) begin
            state_nxt = REPLAY;
          end
        end
      end
      REPLAY: begin
        if (out_free) begin
          load_out = 1'b1;
          nxt_flit = rep_flit;
          rd_inc   = 1'b1;
          if (rep_last) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, sticky error, header latch and capture pointers
  always_ff @(posedge clk) begin
    if (!rst_) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_port  <= '0;
      err       <= 1'b0;
      lat_port  <= '0;
      lat_addr  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load_out) begin
        out_valid <= 1'b1;
        out_flit  <= nxt_flit;
        out_port  <= nxt_port;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (set_err) begin
        err <= 1'b1;
      end
      if (latch_hdr) begin
        lat_port <= dec_port;
        lat_addr <= dec_addr1_rm;
      end
      if (state_nxt == IDLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        if (cap_we) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (rd_inc) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (set_ovf) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Capture buffer storage; the pointers alone decide what is valid
  always_ff @(posedge clk) begin
    if (cap_we) begin
      cap_buf[wr_ptr[IW-1:0]] <= in_flit;
    end
  end

endmodule

// File: tb/tb_mc_fork.sv
// tb_mc_fork: directed tests for mc_fork with hand-computed expected flits.
module tb_mc_fork;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_flit = '0;
  logic [2:0]  dec_port = '0;
  logic [19:0] dec_addr1_rm = '0;
  logic        dec_fwdab_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_flit;
  logic [2:0]  out_port;
  logic        err;

  int checks = 0;
  int errors = 0;

  mc_fork #(.FLITW(64), .MAXLEN(4)) dut (
    .clk(clk), .rst_(rst_),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .dec_port(dec_port), .dec_addr1_rm(dec_addr1_rm), .dec_fwdab_en(dec_fwdab_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_port(out_port), .err(err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [61:0] p);
    return {t, p};
  endfunction

  // Advance to 1 ns past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    in_valid = 1'b1;
    in_flit = mk(2'b01, 62'h1);
    step();
    step();
    checks++;
    if ({out_valid, out_port, out_flit, err} !== 69'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {out_valid, out_port, out_flit, err});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    in_valid = 1'b0;
    rst_ = 1'b1;
    step();
  endtask

  task automatic test_unicast();
    logic [63:0] f [3];
    f[0] = mk(2'b01, 62'h1111_2222_0004_2);
    f[1] = mk(2'b00, 62'h0BAD_CAFE_0001);
    f[2] = mk(2'b10, 62'h0FEE_D000_0002);
    dec_port = 3'd1;
    dec_addr1_rm = 20'h00040;
    dec_fwdab_en = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_flit = f[0];
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unicast_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      in_flit = f[i];
      step();
      checks++;
      if ({out_valid, out_port, out_flit} !== {1'b1, 3'd1, f[i]}) begin
        errors++;
        $display("[TB] FAIL unicast_flit%0d: got %h expected %h", i, {out_valid, out_port, out_flit}, {1'b1, 3'd1, f[i]});
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unicast_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fwdab();
    logic [63:0] f [3];
    logic [63:0] rw;
    f[0] = mk(2'b01, 62'h5A5A_0000_0021);
    f[1] = mk(2'b00, 62'h0123_4567_89AB);
    f[2] = mk(2'b10, 62'h0FED_CBA9_8765);
    rw = {f[0][63:20], 20'h00020};
    dec_port = 3'd2;
    dec_addr1_rm = 20'h00020;
    dec_fwdab_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_flit = f[i];
      step();
      checks++;
      if ({out_valid, out_port, out_flit} !== {1'b1, 3'd4, f[i]}) begin
        errors++;
        $display("[TB] FAIL fwdab_local%0d: got %h expected %h", i, {out_valid, out_port, out_flit}, {1'b1, 3'd4, f[i]});
      end
    end
    in_valid = 1'b0;
    dec_fwdab_en = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwdab_replay_in_ready: got %b expected 0", in_ready);
    end
    f[0] = rw;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out_valid, out_port, out_flit} !== {1'b1, 3'd2, f[i]}) begin
        errors++;
        $display("[TB] FAIL fwdab_replay%0d: got %h expected %h", i, {out_valid, out_port, out_flit}, {1'b1, 3'd2, f[i]});
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwdab_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_single();
    logic [63:0] f;
    logic [63:0] rw;
    f = mk(2'b11, 62'h0777_0000_00F0);
    rw = {f[63:20], 20'h000E0};
    dec_port = 3'd3;
    dec_addr1_rm = 20'h000E0;
    dec_fwdab_en = 1'b1;
    in_valid = 1'b1;
    in_flit = f;
    step();
    in_valid = 1'b0;
    dec_fwdab_en = 1'b0;
    checks++;
    if ({out_valid, out_port, out_flit} !== {1'b1, 3'd4, f}) begin
      errors++;
      $display("[TB] FAIL single_local: got %h expected %h", {out_valid, out_port, out_flit}, {1'b1, 3'd4, f});
    end
    step();
    checks++;
    if ({out_valid, out_port, out_flit} !== {1'b1, 3'd3, rw}) begin
      errors++;
      $display("[TB] FAIL single_replay: got %h expected %h", {out_valid, out_port, out_flit}, {1'b1, 3'd3, rw});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_back_to_idle: in_ready got %b expected 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] f [4];
    f[0] = mk(2'b01, 62'h0AAA_0000_0010);
    f[1] = mk(2'b00, 62'h0BBB_BBBB_BBBB);
    f[2] = mk(2'b00, 62'h0CCC_CCCC_CCCC);
    f[3] = mk(2'b10, 62'h0DDD_DDDD_DDDD);
    dec_port = 3'd2;
    dec_fwdab_en = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_flit = f[0];
    step();
    out_ready = 1'b0;
    in_flit = f[1];
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_valid, out_port, out_flit, in_ready} !== {1'b1, 3'd2, f[0], 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d: got %h expected %h", i, {out_valid, out_port, out_flit, in_ready}, {1'b1, 3'd2, f[0], 1'b0});
      end
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      in_flit = f[i];
      step();
      checks++;
      if ({out_valid, out_port, out_flit} !== {1'b1, 3'd2, f[i]}) begin
        errors++;
        $display("[TB] FAIL stall_resume%0d: got %h expected %h", i, {out_valid, out_port, out_flit}, {1'b1, 3'd2, f[i]});
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] f [6];
    logic [63:0] e [4];
    f[0] = mk(2'b01, 62'h0F0F_0000_0009);
    for (int i = 1; i < 5; i++) begin
      f[i] = mk(2'b00, 62'h0100_0000_0000 + 62'(i));
    end
    f[5] = mk(2'b10, 62'h0200_0000_0005);
    e[0] = {f[0][63:20], 20'h00008};
    e[1] = f[1];
    e[2] = f[2];
    e[3] = {2'b10, f[3][61:0]};
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_err_before: got %b expected 0", err);
    end
    dec_port = 3'd0;
    dec_addr1_rm = 20'h00008;
    dec_fwdab_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_flit = f[i];
      step();
      checks++;
      if ({out_valid, out_port, out_flit} !== {1'b1, 3'd4, f[i]}) begin
        errors++;
        $display("[TB] FAIL overflow_local%0d: got %h expected %h", i, {out_valid, out_port, out_flit}, {1'b1, 3'd4, f[i]});
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (err !== (i == 4)) begin
          errors++;
          $display("[TB] FAIL overflow_err_at%0d: got %b expected %b", i, err, (i == 4));
        end
      end
    end
    in_valid = 1'b0;
    dec_fwdab_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({out_valid, out_port, out_flit} !== {1'b1, 3'd0, e[i]}) begin
        errors++;
        $display("[TB] FAIL overflow_replay%0d: got %h expected %h", i, {out_valid, out_port, out_flit}, {1'b1, 3'd0, e[i]});
      end
    end
    step();
    checks++;
    if ({out_valid, err} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL overflow_drain: valid/err got %b expected 01", {out_valid, err});
    end
  endtask

  task automatic test_reset_replay();
    logic [63:0] f [3];
    logic [63:0] u;
    f[0] = mk(2'b01, 62'h0333_0000_0180);
    f[1] = mk(2'b00, 62'h0444_4444_4444);
    f[2] = mk(2'b10, 62'h0555_5555_5555);
    u = mk(2'b11, 62'h0666_0000_0002);
    dec_port = 3'd3;
    dec_addr1_rm = 20'h00100;
    dec_fwdab_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_flit = f[i];
      step();
    end
    in_valid = 1'b0;
    dec_fwdab_en = 1'b0;
    step();
    checks++;
    if ({out_valid, out_port, out_flit} !== {1'b1, 3'd3, f[0][63:20], 20'h00100}) begin
      errors++;
      $display("[TB] FAIL rstrep_first: got %h expected %h", {out_valid, out_port, out_flit}, {1'b1, 3'd3, f[0][63:20], 20'h00100});
    end
    rst_ = 1'b0;
    step();
    checks++;
    if ({out_valid, out_port, out_flit, err, in_ready} !== 70'b0) begin
      errors++;
      $display("[TB] FAIL rstrep_reset: got %h expected 0", {out_valid, out_port, out_flit, err, in_ready});
    end
    rst_ = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstrep_no_partial: got %b expected 0", out_valid);
    end
    dec_port = 3'd1;
    in_valid = 1'b1;
    in_flit = u;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_port, out_flit} !== {1'b1, 3'd1, u}) begin
      errors++;
      $display("[TB] FAIL rstrep_next_head: got %h expected %h", {out_valid, out_port, out_flit}, {1'b1, 3'd1, u});
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstrep_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_drop();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_err_before: got %b expected 0", err);
    end
    in_valid = 1'b1;
    in_flit = mk(2'b00, 62'h0999_9999_9999);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, err} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL drop_body_in_idle: valid/err got %b expected 01", {out_valid, err});
    end
  endtask

  initial begin
    $display("[TB] starting mc_fork tests");
    test_reset();
    test_unicast();
    test_fwdab();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_replay();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
